// File: rtl/load_store_ctrl_if.sv
// Load/store controller bus bundle: MEM-stage request/response and data-memory port.
// master: controller side (drives req_ready/stall/rsp_*/dm_* requests).
// slave : pipeline + memory side (drives req_* and dm_ack/dm_rdata).
interface load_store_ctrl_if;
    logic        req_valid;
    logic        req_we;
    logic [2:0]  req_func3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        req_ready;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [3:0]  dm_be;
    logic [31:0] dm_wdata;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        input  req_valid, req_we, req_func3, req_addr, req_wdata, dm_ack, dm_rdata,
        output req_ready, stall, rsp_valid, rsp_data, rsp_err,
               dm_req, dm_we, dm_addr, dm_be, dm_wdata
    );

    modport slave (
        output req_valid, req_we, req_func3, req_addr, req_wdata, dm_ack, dm_rdata,
        input  req_ready, stall, rsp_valid, rsp_data, rsp_err,
               dm_req, dm_we, dm_addr, dm_be, dm_wdata
    );
endinterface

// File: rtl/load_store_ctrl.sv
// MEM-stage load/store sequencer for a single-ported, variable-latency data memory.
// Byte-lane enables, load alignment/extension, misalignment detection, ack timeout.
// Optional feature macro MISALIGN_SPLIT_EN: misaligned accesses become two word accesses.
module load_store_ctrl #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    load_store_ctrl_if.master bus
);

    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
`ifdef MISALIGN_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, ACC, ACC2, RESP} state_t;

    state_t        st, nxt;
    logic          r_we, r_err, r_mis;
    logic [2:0]    r_f3;
    logic [31:0]   r_addr, r_wdata, r_data;
    logic [CW-1:0] cnt;
    logic          mis_in, split_first, tmo;
    logic          ready, stall_c, acc, rv;
    logic [4:0]    sh;
    logic [3:0]    base_be, acc_be;
    logic [31:0]   rep, acc_wd, acc_addr, ld_word;
`ifdef MISALIGN_SPLIT_EN
    logic [31:0]   rd1, raw;
    logic [7:0]    win_be;
    logic [63:0]   win_wd, ld_win;
`endif

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] o);
        return ((f3[1:0] == 2'b01) && o[0]) || ((f3 == 3'b010) && (o != 2'b00));
    endfunction

    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign mis_in      = misaligned(bus.req_func3, bus.req_addr[1:0]);
    assign split_first = SPLIT_EN && r_mis;
    assign tmo         = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1));
    assign sh          = {r_addr[1:0], 3'b000};

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else     st <= nxt;
    end

    // Next-state and handshake outputs
    always_comb begin
        nxt     = st;
        ready   = 1'b0;
        stall_c = 1'b0;
        acc     = 1'b0;
        rv      = 1'b0;
        case (st)
            IDLE: begin
                ready   = 1'b1;
                stall_c = bus.req_valid;
                if (bus.req_valid) nxt = (mis_in && !SPLIT_EN) ? RESP : ACC;
            end
            ACC: begin
                acc     = 1'b1;
                stall_c = 1'b1;
                if (bus.dm_ack) nxt = split_first ? ACC2 : RESP;
                else if (tmo)   nxt = RESP;
            end
            ACC2: begin
                acc     = 1'b1;
                stall_c = 1'b1;
                if (bus.dm_ack || tmo) nxt = RESP;
            end
            RESP: begin
                rv  = 1'b1;
                nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Lane enables, store data, address and load alignment from the registered request
    always_comb begin
        case (r_f3[1:0])
            2'b00:   begin base_be = 4'b0001; rep = {4{r_wdata[7:0]}};  end
            2'b01:   begin base_be = 4'b0011; rep = {2{r_wdata[15:0]}}; end
            default: begin base_be = 4'b1111; rep = r_wdata;            end
        endcase
        acc_be   = base_be << r_addr[1:0];
        acc_wd   = rep;
        acc_addr = {r_addr[31:2] + ((st == ACC2) ? 30'd1 : 30'd0), 2'b00};
        ld_word  = bus.dm_rdata >> sh;
`ifdef MISALIGN_SPLIT_EN
        // Misaligned accesses use an 8-byte window: low word in ACC, high word in ACC2.
        raw    = (r_f3[1:0] == 2'b01) ? {16'd0, r_wdata[15:0]} : r_wdata;
        win_be = {4'b0000, base_be} << r_addr[1:0];
        win_wd = {32'd0, raw} << sh;
        ld_win = {bus.dm_rdata, rd1} >> sh;
        if (r_mis) begin
            acc_be  = (st == ACC2) ? win_be[7:4]  : win_be[3:0];
            acc_wd  = (st == ACC2) ? win_wd[63:32] : win_wd[31:0];
            ld_word = ld_win[31:0];
        end
`endif
    end

    // Request capture, timeout counter and response data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_f3    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_mis   <= 1'b0;
            r_err   <= 1'b0;
            r_data  <= '0;
            cnt     <= '0;
        end else begin
            case (st)
                IDLE: if (bus.req_valid) begin
                    r_we    <= bus.req_we;
                    r_f3    <= bus.req_func3;
                    r_addr  <= bus.req_addr;
                    r_wdata <= bus.req_wdata;
                    r_mis   <= mis_in;
                    r_err   <= mis_in && !SPLIT_EN;
                    r_data  <= '0;
                    cnt     <= '0;
                end
                ACC, ACC2: begin
                    if (bus.dm_ack) begin
                        cnt <= '0;
                        if (!(st == ACC && split_first))
                            r_data <= r_we ? '0 : extend(r_f3, ld_word);
                    end else if (tmo) begin
                        r_err  <= 1'b1;
                        r_data <= '0;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef MISALIGN_SPLIT_EN
    // First half of a split load, combined with the second word on the final ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              rd1 <= '0;
        else if (st == ACC && bus.dm_ack && r_mis) rd1 <= bus.dm_rdata;
    end
`endif

    assign bus.req_ready = ready;
    assign bus.stall     = stall_c;
    assign bus.rsp_valid = rv;
    assign bus.rsp_data  = rv ? r_data : '0;
    assign bus.rsp_err   = rv & r_err;
    assign bus.dm_req    = acc;
    assign bus.dm_we     = acc & r_we;
    assign bus.dm_addr   = acc ? acc_addr : '0;
    assign bus.dm_be     = acc ? acc_be : '0;
    assign bus.dm_wdata  = acc ? acc_wd : '0;

endmodule

// File: tb/tb_load_store_ctrl.sv
// Directed testbench for load_store_ctrl. Inputs change on the falling edge,
// outputs are sampled 1 ns later, well away from the rising edge.
module tb_load_store_ctrl;

    localparam int unsigned TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    load_store_ctrl_if bus();

    load_store_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task drive_idle();
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_func3 = 3'b000;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.dm_ack    = 1'b0;
        bus.dm_rdata  = '0;
    endtask

    task drive_req(input logic we, input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_func3 = f3;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
    endtask

    task test_reset();
        drive_idle();
        #2;
        n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b want 1", bus.req_ready); end
        n_checks++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", bus.stall); end
        n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_checks++; if (bus.rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        n_checks++; if (bus.dm_req !== 1'b0) begin n_fail++; $display("FAIL reset_dm_req: got %b want 0", bus.dm_req); end
        n_checks++; if ({bus.dm_we, bus.dm_be, bus.dm_addr, bus.dm_wdata, bus.rsp_err} !== '0) begin
            n_fail++; $display("FAIL reset_dm_outs: we=%b be=%b addr=%h wd=%h err=%b want all 0",
                               bus.dm_we, bus.dm_be, bus.dm_addr, bus.dm_wdata, bus.rsp_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task test_load_ext();
        logic [2:0]  f3  [9];
        logic [31:0] ad  [9];
        logic [31:0] exp [9];
        f3  = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b011, 3'b000, 3'b100};
        ad  = '{32'h103, 32'h100, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101, 32'h101, 32'h103};
        exp = '{32'hFFFF_FF80, 32'h0000_0034, 32'h0000_00FF, 32'hFFFF_80FF, 32'h0000_1234,
                32'h80FF_1234, 32'h0080_FF12, 32'h0000_0012, 32'h0000_0080};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_req(1'b0, f3[i], ad[i], 32'h0);
            #1;
            n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL ld%0d_accept_stall: got %b want 1", i, bus.stall); end
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.dm_ack    = 1'b1;
            bus.dm_rdata  = 32'h80FF_1234;
            #1;
            n_checks++; if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b0) begin n_fail++; $display("FAIL ld%0d_dm_req: got req=%b we=%b want 1/0", i, bus.dm_req, bus.dm_we); end
            n_checks++; if (bus.dm_addr !== {ad[i][31:2], 2'b00}) begin n_fail++; $display("FAIL ld%0d_dm_addr: got %h want %h", i, bus.dm_addr, {ad[i][31:2], 2'b00}); end
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL ld%0d_early_rsp: got %b want 0", i, bus.rsp_valid); end
            @(negedge clk);
            bus.dm_ack = 1'b0;
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL ld%0d_rsp: got valid=%b err=%b want 1/0", i, bus.rsp_valid, bus.rsp_err); end
            n_checks++; if (bus.rsp_data !== exp[i]) begin n_fail++; $display("FAIL ld%0d_data: got %h want %h", i, bus.rsp_data, exp[i]); end
            n_checks++; if (bus.stall !== 1'b0 || bus.dm_req !== 1'b0) begin n_fail++; $display("FAIL ld%0d_resp_stall: got stall=%b req=%b want 0/0", i, bus.stall, bus.dm_req); end
        end
        @(negedge clk);
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL ld_back_idle: got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
    endtask

    task test_store_lanes();
        logic [2:0]  f3  [4];
        logic [31:0] ad  [4];
        logic [31:0] wd  [4];
        logic [3:0]  ebe [4];
        logic [31:0] ewd [4];
        f3  = '{3'b001, 3'b000, 3'b010, 3'b000};
        ad  = '{32'h202, 32'h301, 32'h400, 32'h303};
        wd  = '{32'h0000_ABCD, 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_00A5};
        ebe = '{4'b1100, 4'b0010, 4'b1111, 4'b1000};
        ewd = '{32'hABCD_ABCD, 32'h7878_7878, 32'hDEAD_BEEF, 32'hA5A5_A5A5};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive_req(1'b1, f3[i], ad[i], wd[i]);
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.dm_ack    = 1'b1;
            #1;
            n_checks++; if (bus.dm_req !== 1'b1 || bus.dm_we !== 1'b1) begin n_fail++; $display("FAIL st%0d_dm_we: got req=%b we=%b want 1/1", i, bus.dm_req, bus.dm_we); end
            n_checks++; if (bus.dm_be !== ebe[i]) begin n_fail++; $display("FAIL st%0d_be: got %b want %b", i, bus.dm_be, ebe[i]); end
            n_checks++; if (bus.dm_wdata !== ewd[i]) begin n_fail++; $display("FAIL st%0d_wdata: got %h want %h", i, bus.dm_wdata, ewd[i]); end
            n_checks++; if (bus.dm_addr !== {ad[i][31:2], 2'b00}) begin n_fail++; $display("FAIL st%0d_addr: got %h want %h", i, bus.dm_addr, {ad[i][31:2], 2'b00}); end
            @(negedge clk);
            bus.dm_ack = 1'b0;
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h0) begin
                n_fail++; $display("FAIL st%0d_rsp: got valid=%b err=%b data=%h want 1/0/0", i, bus.rsp_valid, bus.rsp_err, bus.rsp_data);
            end
        end
    endtask

    task test_misaligned();
`ifdef MISALIGN_SPLIT_EN
        // Split load: words 0x44332211 / 0x88776655 at offset 1
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h101, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.dm_ack    = 1'b1;
        bus.dm_rdata  = 32'h4433_2211;
        #1;
        n_checks++; if (bus.dm_req !== 1'b1 || bus.dm_addr !== 32'h100) begin n_fail++; $display("FAIL split_ld_acc1: got req=%b addr=%h want 1/100", bus.dm_req, bus.dm_addr); end
        @(negedge clk);
        bus.dm_rdata = 32'h8877_6655;
        #1;
        n_checks++; if (bus.dm_req !== 1'b1 || bus.dm_addr !== 32'h104) begin n_fail++; $display("FAIL split_ld_acc2: got req=%b addr=%h want 1/104", bus.dm_req, bus.dm_addr); end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0 || bus.rsp_data !== 32'h5544_3322) begin
            n_fail++; $display("FAIL split_ld_rsp: got valid=%b err=%b data=%h want 1/0/55443322", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
        // Split store: SW 0xAABBCCDD at 0x102 spans lanes 2,3 then 0,1
        @(negedge clk);
        drive_req(1'b1, 3'b010, 32'h102, 32'hAABB_CCDD);
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.dm_ack    = 1'b1;
        #1;
        n_checks++; if (bus.dm_be !== 4'b1100 || bus.dm_wdata[31:16] !== 16'hCCDD) begin n_fail++; $display("FAIL split_st_acc1: got be=%b wd=%h want 1100/CCDDxxxx", bus.dm_be, bus.dm_wdata); end
        @(negedge clk);
        #1;
        n_checks++; if (bus.dm_be !== 4'b0011 || bus.dm_wdata[15:0] !== 16'hAABB || bus.dm_addr !== 32'h104) begin
            n_fail++; $display("FAIL split_st_acc2: got be=%b wd=%h addr=%h want 0011/xxxxAABB/104", bus.dm_be, bus.dm_wdata, bus.dm_addr);
        end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL split_st_rsp: got valid=%b err=%b want 1/0", bus.rsp_valid, bus.rsp_err); end
`else
        logic        we [3];
        logic [2:0]  f3 [3];
        logic [31:0] ad [3];
        we = '{1'b0, 1'b1, 1'b0};
        f3 = '{3'b010, 3'b001, 3'b101};
        ad = '{32'h101, 32'h203, 32'h105};
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_req(we[i], f3[i], ad[i], 32'hFFFF_FFFF);
            #1;
            n_checks++; if (bus.stall !== 1'b1) begin n_fail++; $display("FAIL mis%0d_accept_stall: got %b want 1", i, bus.stall); end
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.dm_ack    = 1'b1;
            bus.dm_rdata  = 32'h1234_5678;
            #1;
            n_checks++; if (bus.dm_req !== 1'b0) begin n_fail++; $display("FAIL mis%0d_dm_req: got %b want 0", i, bus.dm_req); end
            n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0) begin
                n_fail++; $display("FAIL mis%0d_rsp: got valid=%b err=%b data=%h want 1/1/0", i, bus.rsp_valid, bus.rsp_err, bus.rsp_data);
            end
            bus.dm_ack = 1'b0;
        end
`endif
    endtask

    task test_ack_delay();
        int stall_hi;
        stall_hi = 0;
        @(negedge clk);
        drive_req(1'b0, 3'b101, 32'h102, 32'h0);
        bus.dm_rdata = 32'h9876_0000;
        // Five waiting cycles, ack on the sixth cycle of the access
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_valid = 1'b0;
            bus.dm_ack    = (i == 5);
            #1;
            if (bus.stall === 1'b1 && bus.dm_req === 1'b1) stall_hi++;
            n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL delay_early_rsp%0d: got %b want 0", i, bus.rsp_valid); end
        end
        n_checks++; if (stall_hi != 6) begin n_fail++; $display("FAIL delay_stall_cycles: got %0d want 6", stall_hi); end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h0000_9876 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL delay_rsp: got valid=%b data=%h stall=%b want 1/00009876/0", bus.rsp_valid, bus.rsp_data, bus.stall);
        end
    endtask

    task test_timeout();
        int acc_cycles;
        acc_cycles = 0;
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h500, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (bus.dm_req !== 1'b1) break;
            acc_cycles++;
            @(negedge clk);
        end
        n_checks++; if (acc_cycles != TIMEOUT) begin n_fail++; $display("FAIL timeout_cycles: got %0d want %0d", acc_cycles, TIMEOUT); end
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_err !== 1'b1 || bus.rsp_data !== 32'h0) begin
            n_fail++; $display("FAIL timeout_rsp: got valid=%b err=%b data=%h want 1/1/0", bus.rsp_valid, bus.rsp_err, bus.rsp_data);
        end
    endtask

    task test_reset_mid_access();
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h600, 32'h0);
        @(negedge clk);
        bus.req_valid = 1'b0;
        #1;
        n_checks++; if (bus.dm_req !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_req: got %b want 1", bus.dm_req); end
        #1;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.dm_req !== 1'b0 || bus.req_ready !== 1'b1 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL rstmid_drop: got req=%b ready=%b stall=%b want 0/1/0", bus.dm_req, bus.req_ready, bus.stall);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.dm_ack = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
                n_fail++; $display("FAIL rstmid_after%0d: got valid=%b ready=%b want 0/1", i, bus.rsp_valid, bus.req_ready);
            end
            @(negedge clk);
        end
        bus.dm_ack = 1'b0;
    endtask

    task test_back_to_back();
        drive_idle();
        @(negedge clk);
        bus.dm_ack = 1'b1;
        #1;
        n_checks++; if (bus.dm_req !== 1'b0) begin n_fail++; $display("FAIL stray_ack_req: got %b want 0", bus.dm_req); end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL stray_ack_rsp: got valid=%b ready=%b want 0/1", bus.rsp_valid, bus.req_ready); end
        drive_req(1'b0, 3'b000, 32'h100, 32'h0);
        @(negedge clk);
        drive_req(1'b0, 3'b010, 32'h200, 32'h0);
        bus.dm_ack   = 1'b1;
        bus.dm_rdata = 32'h1122_3344;
        #1;
        n_checks++; if (bus.dm_addr !== 32'h100) begin n_fail++; $display("FAIL b2b_addr1: got %h want 100", bus.dm_addr); end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h44 || bus.req_ready !== 1'b0 || bus.stall !== 1'b0) begin
            n_fail++; $display("FAIL b2b_rsp1: got valid=%b data=%h ready=%b stall=%b want 1/44/0/0", bus.rsp_valid, bus.rsp_data, bus.req_ready, bus.stall);
        end
        @(negedge clk);
        #1;
        n_checks++; if (bus.req_ready !== 1'b1 || bus.stall !== 1'b1 || bus.dm_req !== 1'b0) begin
            n_fail++; $display("FAIL b2b_accept2: got ready=%b stall=%b req=%b want 1/1/0", bus.req_ready, bus.stall, bus.dm_req);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
        bus.dm_ack    = 1'b1;
        bus.dm_rdata  = 32'hCAFE_F00D;
        #1;
        n_checks++; if (bus.dm_req !== 1'b1 || bus.dm_addr !== 32'h200) begin n_fail++; $display("FAIL b2b_addr2: got req=%b addr=%h want 1/200", bus.dm_req, bus.dm_addr); end
        @(negedge clk);
        bus.dm_ack = 1'b0;
        #1;
        n_checks++; if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'hCAFE_F00D) begin
            n_fail++; $display("FAIL b2b_rsp2: got valid=%b data=%h want 1/CAFEF00D", bus.rsp_valid, bus.rsp_data);
        end
    endtask

    initial begin
        test_reset();
        test_load_ext();
        test_store_lanes();
        test_misaligned();
        test_ack_delay();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
